// File: rtl/rinsc_control_unit_pkg.sv
// Shared types and encodings for the RINSC ID-stage controller.
// The opcode map, control bundle layout and ALU/mux select codes are defined here.
package rinsc_pkg;

    localparam int SB_DEPTH = 3;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_ADD  = 8'h01,
        OP_SUB  = 8'h02,
        OP_MUL  = 8'h03,
        OP_XOR  = 8'h04,
        OP_OR   = 8'h05,
        OP_AND  = 8'h06,
        OP_SLL  = 8'h07,
        OP_SRA  = 8'h08,
        OP_SRL  = 8'h09,
        OP_ADDI = 8'h0A,
        OP_LW   = 8'h0B,
        OP_SW   = 8'h0C,
        OP_J    = 8'h0D,
        OP_JAL  = 8'h0E
    } op_e;

    typedef enum logic [1:0] {
        ST_WARM  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_e;

    localparam logic [3:0] ALUOP_ADD = 4'b0000;
    localparam logic [3:0] ALUOP_SUB = 4'b0001;
    localparam logic [3:0] ALUOP_MUL = 4'b0010;
    localparam logic [3:0] ALUOP_XOR = 4'b0011;
    localparam logic [3:0] ALUOP_OR  = 4'b0100;
    localparam logic [3:0] ALUOP_AND = 4'b0101;
    localparam logic [3:0] ALUOP_SLL = 4'b0110;
    localparam logic [3:0] ALUOP_SRA = 4'b0111;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;

    localparam logic [1:0] ALUSRC_DB    = 2'b00;
    localparam logic [1:0] ALUSRC_SEXT  = 2'b01;
    localparam logic [1:0] ALUSRC_SHAMT = 2'b10;

    localparam logic [1:0] M2R_MEM = 2'b00;
    localparam logic [1:0] M2R_ALU = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic [1:0] mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // One in-flight writer as seen by the scoreboard
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_t;

    function automatic ctrl_t alu_ctrl(input logic [3:0] alu_op, input logic [1:0] alu_src);
        ctrl_t c;
        c            = CTRL_BUBBLE;
        c.alu_op     = alu_op;
        c.alu_src    = alu_src;
        c.mem_to_reg = M2R_ALU;
        c.reg_write  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/rinsc_control_unit_if.sv
// IF/ID fields in, ID/EX control bundle and status out.
// The datapath side is the master; the control unit is the slave.
interface rinsc_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       Op;
    logic [4:0]       Rs1;
    logic [4:0]       Rs2;
    logic [4:0]       Rd;
    logic [3:0]       ALUOp;
    logic [1:0]       ALUSrc;
    logic [1:0]       MemToReg;
    logic             MemRead;
    logic             MemWrite;
    logic             RegWrite;
    logic             PCSrc;
    logic             Stall;
    logic             Flush;
    logic             IllegalOp;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output Op, Rs1, Rs2, Rd,
        input  ALUOp, ALUSrc, MemToReg, MemRead, MemWrite, RegWrite,
               PCSrc, Stall, Flush, IllegalOp, StallCount
    );

    modport slave (
        input  Op, Rs1, Rs2, Rd,
        output ALUOp, ALUSrc, MemToReg, MemRead, MemWrite, RegWrite,
               PCSrc, Stall, Flush, IllegalOp, StallCount
    );
endinterface

// File: rtl/rinsc_control_unit_hazard.sv
// RAW hazard detector: EX/MEM/WB writer scoreboard plus source comparators.
// No forwarding exists, so a match in any stage (including WB) stalls.
module rinsc_hazard_unit
    import rinsc_pkg::*;
#(
    parameter bit R0_IS_ZERO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_use_rs1,
    input  logic       i_use_rs2,
    input  logic       i_issue_valid,
    input  logic [4:0] i_issue_rd,
    output logic       o_hazard
);
    sb_t [SB_DEPTH-1:0] r_sb;
    sb_t                w_ex_entry;
    logic [SB_DEPTH-1:0] w_hit1;
    logic [SB_DEPTH-1:0] w_hit2;
    logic               w_rs1_live;
    logic               w_rs2_live;

    assign w_ex_entry.valid = i_issue_valid && !(R0_IS_ZERO && (i_issue_rd == 5'd0));
    assign w_ex_entry.rd    = i_issue_rd;

    // Index 0 is EX, SB_DEPTH-1 is WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb[0] <= w_ex_entry;
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    for (genvar g = 0; g < SB_DEPTH; g++) begin : g_cmp
        assign w_hit1[g] = r_sb[g].valid && (r_sb[g].rd == i_rs1);
        assign w_hit2[g] = r_sb[g].valid && (r_sb[g].rd == i_rs2);
    end

    assign w_rs1_live = i_use_rs1 && !(R0_IS_ZERO && (i_rs1 == 5'd0));
    assign w_rs2_live = i_use_rs2 && !(R0_IS_ZERO && (i_rs2 == 5'd0));
    assign o_hazard   = (w_rs1_live && |w_hit1) || (w_rs2_live && |w_hit2);

endmodule

// File: rtl/rinsc_control_unit.sv
// ID-stage controller: opcode decoder, WARM/RUN/STALL FSM and saturating stall counter.
// Control outputs are combinational from IF/ID and registered state.
module rinsc_control_unit
    import rinsc_pkg::*;
#(
    parameter bit R0_IS_ZERO = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    rinsc_control_unit_if.slave io_bus
);
    state_e           r_state;
    state_e           w_state_nxt;
    ctrl_t            w_dec;
    ctrl_t            w_ctrl;
    logic             w_ill_dec;
    logic             w_use_rs1;
    logic             w_use_rs2;
    logic             w_hazard;
    logic             w_stall;
    logic             w_illegal;
    logic [CNT_W-1:0] r_stall_cnt;

    always_comb begin
        w_dec     = CTRL_BUBBLE;
        w_ill_dec = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (io_bus.Op)
            OP_NOP: ;
            OP_ADD:  begin w_dec = alu_ctrl(ALUOP_ADD, ALUSRC_DB); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_SUB:  begin w_dec = alu_ctrl(ALUOP_SUB, ALUSRC_DB); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_MUL:  begin w_dec = alu_ctrl(ALUOP_MUL, ALUSRC_DB); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_XOR:  begin w_dec = alu_ctrl(ALUOP_XOR, ALUSRC_DB); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_OR:   begin w_dec = alu_ctrl(ALUOP_OR,  ALUSRC_DB); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_AND:  begin w_dec = alu_ctrl(ALUOP_AND, ALUSRC_DB); w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_SLL:  begin w_dec = alu_ctrl(ALUOP_SLL, ALUSRC_SHAMT); w_use_rs1 = 1'b1; end
            OP_SRA:  begin w_dec = alu_ctrl(ALUOP_SRA, ALUSRC_SHAMT); w_use_rs1 = 1'b1; end
            OP_SRL:  begin w_dec = alu_ctrl(ALUOP_SRL, ALUSRC_SHAMT); w_use_rs1 = 1'b1; end
            OP_ADDI: begin w_dec = alu_ctrl(ALUOP_ADD, ALUSRC_SEXT); w_use_rs1 = 1'b1; end
            OP_LW: begin
                w_dec.mem_read   = 1'b1;
                w_dec.alu_src    = ALUSRC_SEXT;
                w_dec.mem_to_reg = M2R_MEM;
                w_dec.reg_write  = 1'b1;
                w_use_rs1        = 1'b1;
            end
            OP_SW: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = ALUSRC_SEXT;
                w_use_rs1       = 1'b1;
                w_use_rs2       = 1'b1;
            end
            OP_J: w_dec.pc_src = 1'b1;
            OP_JAL: begin
                w_dec.pc_src     = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.mem_to_reg = M2R_PC4;
            end
            default: w_ill_dec = 1'b1;
        endcase
    end

    rinsc_hazard_unit #(
        .R0_IS_ZERO(R0_IS_ZERO)
    ) u_hazard (
        .clk          (clk),
        .rst          (reset),
        .i_rs1        (io_bus.Rs1),
        .i_rs2        (io_bus.Rs2),
        .i_use_rs1    (w_use_rs1),
        .i_use_rs2    (w_use_rs2),
        .i_issue_valid(w_ctrl.reg_write),
        .i_issue_rd   (io_bus.Rd),
        .o_hazard     (w_hazard)
    );

    // STALL exits as soon as the hazard clears, issuing the held op that same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = CTRL_BUBBLE;
        w_stall     = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            ST_WARM: w_state_nxt = ST_RUN;
            ST_RUN, ST_STALL: begin
                if (w_hazard) begin
                    w_stall     = 1'b1;
                    w_state_nxt = ST_STALL;
                end else begin
                    w_ctrl      = w_dec;
                    w_illegal   = w_ill_dec;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_WARM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_WARM;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign io_bus.ALUOp      = w_ctrl.alu_op;
    assign io_bus.ALUSrc     = w_ctrl.alu_src;
    assign io_bus.MemToReg   = w_ctrl.mem_to_reg;
    assign io_bus.MemRead    = w_ctrl.mem_read;
    assign io_bus.MemWrite   = w_ctrl.mem_write;
    assign io_bus.RegWrite   = w_ctrl.reg_write;
    assign io_bus.PCSrc      = w_ctrl.pc_src;
    assign io_bus.Flush      = w_ctrl.pc_src;
    assign io_bus.Stall      = w_stall;
    assign io_bus.IllegalOp  = w_illegal;
    assign io_bus.StallCount = r_stall_cnt;

endmodule

// File: tb/tb_rinsc_control_unit.sv
// Directed table-driven bench for the RINSC ID-stage controller.
// A second instance (R0_IS_ZERO=1, CNT_W=2) covers r0 handling and counter saturation.
module tb_rinsc_control_unit;
    import rinsc_pkg::*;

    typedef struct packed {
        logic [3:0]  aluop;
        logic [1:0]  alusrc;
        logic [1:0]  m2r;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        pcs;
        logic        stall;
        logic        flush;
        logic        ill;
        logic [15:0] cnt;
    } obs_t;

    typedef struct {
        bit         on_z;
        logic [7:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        obs_t       exp;
        bit         m2r_dc;
    } vec_t;

    logic   clk = 1'b0;
    logic   reset;
    int     n_pass = 0;
    int     n_chk  = 0;
    int     n_main;
    vec_t   v[$];

    rinsc_control_unit_if #(.CNT_W(16)) cu();
    rinsc_control_unit_if #(.CNT_W(2))  cz();

    rinsc_control_unit #(.R0_IS_ZERO(1'b0), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .io_bus(cu)
    );
    rinsc_control_unit #(.R0_IS_ZERO(1'b1), .CNT_W(2)) u_dut_z (
        .clk(clk), .reset(reset), .io_bus(cz)
    );

    always #5 clk = ~clk;

    function automatic obs_t iss(logic [3:0] a, logic [1:0] s, logic [1:0] m,
                                 logic mr, logic mw, logic rw, logic pcs, logic [15:0] c);
        obs_t o;
        o = '0;
        o.aluop = a; o.alusrc = s; o.m2r = m;
        o.mr = mr; o.mw = mw; o.rw = rw; o.pcs = pcs; o.flush = pcs;
        o.cnt = c;
        return o;
    endfunction

    function automatic obs_t bub(logic st, logic ill, logic [15:0] c);
        obs_t o;
        o = '0;
        o.stall = st; o.ill = ill; o.cnt = c;
        return o;
    endfunction

    function automatic obs_t sample(bit z);
        obs_t o;
        if (z) o = {cz.ALUOp, cz.ALUSrc, cz.MemToReg, cz.MemRead, cz.MemWrite, cz.RegWrite,
                    cz.PCSrc, cz.Stall, cz.Flush, cz.IllegalOp, 14'd0, cz.StallCount};
        else   o = {cu.ALUOp, cu.ALUSrc, cu.MemToReg, cu.MemRead, cu.MemWrite, cu.RegWrite,
                    cu.PCSrc, cu.Stall, cu.Flush, cu.IllegalOp, cu.StallCount};
        return o;
    endfunction

    task automatic add(bit z, logic [7:0] op, logic [4:0] rs1, logic [4:0] rs2,
                       logic [4:0] rd, obs_t e, bit dc);
        vec_t t;
        t.on_z = z; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.exp = e; t.m2r_dc = dc;
        v.push_back(t);
    endtask

    task automatic check(string name, obs_t got, obs_t exp, bit dc);
        if (dc) begin
            got.m2r = '0;
            exp.m2r = '0;
        end
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic drive(bit z, logic [7:0] op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
        cu.Op = 8'h00; cu.Rs1 = 5'd0; cu.Rs2 = 5'd0; cu.Rd = 5'd0;
        cz.Op = 8'h00; cz.Rs1 = 5'd0; cz.Rs2 = 5'd0; cz.Rd = 5'd0;
        if (z) begin
            cz.Op = op; cz.Rs1 = rs1; cz.Rs2 = rs2; cz.Rd = rd;
        end else begin
            cu.Op = op; cu.Rs1 = rs1; cu.Rs2 = rs2; cu.Rd = rd;
        end
    endtask

    task automatic run_rows(int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            drive(v[i].on_z, v[i].op, v[i].rs1, v[i].rs2, v[i].rd);
            @(negedge clk);
            check($sformatf("row%0d", i), sample(v[i].on_z), v[i].exp, v[i].m2r_dc);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 5'd0, 5'd0, 5'd0);

        // Independent stream after WARM
        add(0, 8'h01, 1, 2, 3, bub(0, 0, 0), 1);
        add(0, 8'h01, 1, 2, 6, iss(ALUOP_ADD, ALUSRC_DB,   M2R_ALU, 0, 0, 1, 0, 0), 0);
        add(0, 8'h02, 1, 2, 7, iss(ALUOP_SUB, ALUSRC_DB,   M2R_ALU, 0, 0, 1, 0, 0), 0);
        add(0, 8'h0A, 2, 0, 8, iss(ALUOP_ADD, ALUSRC_SEXT, M2R_ALU, 0, 0, 1, 0, 0), 0);
        // ADD r3 then ADD r4=r3+r1: three stall cycles
        add(0, 8'h01, 1, 2, 3, iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 0), 0);
        add(0, 8'h01, 3, 1, 4, bub(1, 0, 0), 1);
        add(0, 8'h01, 3, 1, 4, bub(1, 0, 1), 1);
        add(0, 8'h01, 3, 1, 4, bub(1, 0, 2), 1);
        add(0, 8'h01, 3, 1, 4, iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 3), 0);
        // LW r5; NOP; SW rs2=r5: two stall cycles
        add(0, 8'h0B, 9, 0, 5, iss(ALUOP_ADD, ALUSRC_SEXT, M2R_MEM, 1, 0, 1, 0, 3), 0);
        add(0, 8'h00, 0, 0, 0, bub(0, 0, 3), 1);
        add(0, 8'h0C, 1, 5, 0, bub(1, 0, 3), 1);
        add(0, 8'h0C, 1, 5, 0, bub(1, 0, 4), 1);
        add(0, 8'h0C, 1, 5, 0, iss(ALUOP_ADD, ALUSRC_SEXT, M2R_MEM, 0, 1, 0, 0, 5), 1);
        // J then flushed NOP
        add(0, 8'h0D, 0, 0, 0, iss(4'd0, 2'd0, 2'd0, 0, 0, 0, 1, 5), 1);
        add(0, 8'h00, 0, 0, 0, bub(0, 0, 5), 1);
        // Shifts and remaining R-type ops
        add(0, 8'h07,  2,  0,  1, iss(ALUOP_SLL, ALUSRC_SHAMT, M2R_ALU, 0, 0, 1, 0, 5), 0);
        add(0, 8'h08,  3,  0,  2, iss(ALUOP_SRA, ALUSRC_SHAMT, M2R_ALU, 0, 0, 1, 0, 5), 0);
        add(0, 8'h09, 10,  0,  9, iss(ALUOP_SRL, ALUSRC_SHAMT, M2R_ALU, 0, 0, 1, 0, 5), 0);
        add(0, 8'h03, 11, 12, 10, iss(ALUOP_MUL, ALUSRC_DB,    M2R_ALU, 0, 0, 1, 0, 5), 0);
        add(0, 8'h04, 13, 14, 11, iss(ALUOP_XOR, ALUSRC_DB,    M2R_ALU, 0, 0, 1, 0, 5), 0);
        add(0, 8'h05, 13, 14, 12, iss(ALUOP_OR,  ALUSRC_DB,    M2R_ALU, 0, 0, 1, 0, 5), 0);
        add(0, 8'h06, 14, 15, 13, iss(ALUOP_AND, ALUSRC_DB,    M2R_ALU, 0, 0, 1, 0, 5), 0);
        // JAL r31 whose unused rs fields match live writers: no stall
        add(0, 8'h0E, 13, 12, 31, iss(4'd0, 2'd0, M2R_PC4, 0, 0, 1, 1, 5), 0);
        add(0, 8'h00,  0,  0,  0, bub(0, 0, 5), 1);
        // Illegal opcodes
        add(0, 8'hFF, 13,  0,  0, bub(0, 1, 5), 1);
        add(0, 8'h0F,  0,  0,  0, bub(0, 1, 5), 1);
        add(0, 8'h00,  0,  0,  0, bub(0, 0, 5), 1);
        // r0 is an ordinary register when R0_IS_ZERO=0
        add(0, 8'h01, 1, 2, 0, iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 5), 0);
        add(0, 8'h01, 0, 1, 1, bub(1, 0, 5), 1);
        add(0, 8'h01, 0, 1, 1, bub(1, 0, 6), 1);
        add(0, 8'h01, 0, 1, 1, bub(1, 0, 7), 1);
        add(0, 8'h01, 0, 1, 1, iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 8), 0);
        n_main = v.size();

        // Second instance: r0 never hazards; 2-bit counter saturates at 3
        add(1, 8'h01, 1, 2, 0, iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 0), 0);
        add(1, 8'h01, 0, 0, 4, iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 0), 0);
        add(1, 8'h01, 1, 2, 3, iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 0), 0);
        add(1, 8'h01, 3, 1, 6, bub(1, 0, 0), 1);
        add(1, 8'h01, 3, 1, 6, bub(1, 0, 1), 1);
        add(1, 8'h01, 3, 1, 6, bub(1, 0, 2), 1);
        add(1, 8'h01, 3, 1, 6, iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 3), 0);
        add(1, 8'h01, 1, 6, 7, bub(1, 0, 3), 1);
        add(1, 8'h01, 1, 6, 7, bub(1, 0, 3), 1);
        add(1, 8'h01, 1, 6, 7, bub(1, 0, 3), 1);
        add(1, 8'h01, 1, 6, 7, iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 3), 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", sample(1'b0), '0, 1'b0);
        reset = 1'b0;

        run_rows(0, n_main);

        // Reset asserted in the middle of a stall
        drive(1'b0, 8'h01, 7, 8, 3);
        @(negedge clk);
        check("rst_a", sample(1'b0), iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 8), 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h01, 3, 9, 4);
        @(negedge clk);
        check("rst_b", sample(1'b0), bub(1, 0, 8), 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_c", sample(1'b0), bub(1, 0, 9), 1'b1);
        #2 reset = 1'b1;
        #1 check("rst_async", sample(1'b0), '0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_warm", sample(1'b0), bub(0, 0, 0), 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_sb_clear", sample(1'b0), iss(ALUOP_ADD, ALUSRC_DB, M2R_ALU, 0, 0, 1, 0, 0), 1'b0);
        @(posedge clk); #1;

        run_rows(n_main, v.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
